// File: rtl/toggle_bank_pkg.sv
// Shared encodings and constants for the toggle_bank channel array.
package toggle_bank_pkg;

    localparam int unsigned CH_IDX_W = 4;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

endpackage

// File: rtl/toggle_channel.sv
// One count-and-toggle channel: counter, limit, mode and registered out/tick.
module toggle_channel
    import toggle_bank_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned DEFAULT_LIMIT = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 wr_en,
    input  logic [CNT_WIDTH-1:0] wr_limit,
    input  mode_e                wr_mode,
    output logic                 out,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] limit;
    mode_e                mode;
    logic                 term_c;
    logic                 mode_chg_c;

    // >= rather than == so a counter stranded above a lowered limit recovers at once
    assign term_c     = cnt >= limit;
    assign mode_chg_c = wr_en && (wr_mode != mode);

    // Old limit and mode judge this cycle; a write lands for the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            limit <= CNT_WIDTH'(DEFAULT_LIMIT);
            mode  <= MODE_TOGGLE;
            out   <= 1'b0;
            tick  <= 1'b0;
        end else begin
            if (wr_en) begin
                limit <= wr_limit;
                mode  <= wr_mode;
            end
            if (!enable) begin
                cnt  <= '0;
                out  <= 1'b0;
                tick <= 1'b0;
            end else begin
                cnt  <= term_c ? '0 : cnt + CNT_WIDTH'(1);
                tick <= term_c;
                // Any mode switch restarts the output from 0
                if (mode_chg_c) begin
                    out <= 1'b0;
                end else if (mode == MODE_PULSE) begin
                    out <= term_c;
                end else if (term_c) begin
                    out <= ~out;
                end
            end
        end
    end

endmodule

// File: rtl/toggle_bank.sv
// Bank of independent count-and-toggle channels with a shared configuration write port.
module toggle_bank
    import toggle_bank_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned DEFAULT_LIMIT = 9
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic [NUM_CH-1:0]    i_Enable,
    input  logic                 i_Wr_En,
    input  logic [CH_IDX_W-1:0]  i_Wr_Ch,
    input  logic [CNT_WIDTH-1:0] i_Wr_Limit,
    input  logic                 i_Wr_Mode,
    output logic [NUM_CH-1:0]    o_Out,
    output logic [NUM_CH-1:0]    o_Tick
);

    mode_e wr_mode_c;
    assign wr_mode_c = mode_e'(i_Wr_Mode);

    // Full-width index compare: indices >= NUM_CH select no channel
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic sel_c;
        assign sel_c = i_Wr_En && (i_Wr_Ch == CH_IDX_W'(n));

        toggle_channel #(
            .CNT_WIDTH     (CNT_WIDTH),
            .DEFAULT_LIMIT (DEFAULT_LIMIT)
        ) u_ch (
            .clk      (i_Clk),
            .reset    (i_Reset),
            .enable   (i_Enable[n]),
            .wr_en    (sel_c),
            .wr_limit (i_Wr_Limit),
            .wr_mode  (wr_mode_c),
            .out      (o_Out[n]),
            .tick     (o_Tick[n])
        );
    end

endmodule

// File: tb/tb_toggle_bank.sv
// Directed bench for toggle_bank: vector table plus multi-cycle corner sequences.
module tb_toggle_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        we;
    logic [3:0]  ch;
    logic [15:0] lim;
    logic        mode;
    logic [3:0]  o_out;
    logic [3:0]  o_tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    toggle_bank #(
        .NUM_CH        (4),
        .CNT_WIDTH     (16),
        .DEFAULT_LIMIT (9)
    ) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_Enable   (en),
        .i_Wr_En    (we),
        .i_Wr_Ch    (ch),
        .i_Wr_Limit (lim),
        .i_Wr_Mode  (mode),
        .o_Out      (o_out),
        .o_Tick     (o_tick)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic        we;
        logic [3:0]  ch;
        logic [15:0] lim;
        logic        mode;
        logic [3:0]  eout;
        logic [3:0]  etick;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic r, input logic [3:0] e, input logic w,
                                input logic [3:0] c, input logic [15:0] l, input logic m,
                                input logic [3:0] eo, input logic [3:0] et);
        vec_t v;
        v.rst = r; v.en = e; v.we = w; v.ch = c; v.lim = l; v.mode = m;
        v.eout = eo; v.etick = et;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [3:0] e, input logic w,
                         input logic [3:0] c, input logic [15:0] l, input logic m);
        rst = r; en = e; we = w; ch = c; lim = l; mode = m;
    endtask

    task automatic step(input string name, input logic [3:0] eo, input logic [3:0] et);
        @(posedge clk);
        #1;
        checks++;
        if (o_out !== eo || o_tick !== et) begin
            errors++;
            $display("FAIL %s: out=%b tick=%b, expected out=%b tick=%b", name, o_out, o_tick, eo, et);
        end
    endtask

    // Channel 0 alone at limit 9, k = enabled cycles since (re)start
    task automatic run_ch0(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            logic t;
            logic o;
            t = (k % 10) == 9;
            o = (((k + 1) / 10) % 2) == 1;
            step($sformatf("%s_k%0d", tag, k), {3'b000, o}, {3'b000, t});
        end
    endtask

    initial begin
        drive(1'b1, 4'h0, 1'b0, 4'h0, 16'd0, 1'b0);

        // Channel 1: toggle at L=2, switch to pulse at L=0, ignored write, disable, L=1
        vecs[0]  = mk(1, 4'h0, 0, 4'd0, 16'd0, 0, 4'h0, 4'h0);
        vecs[1]  = mk(0, 4'h0, 1, 4'd1, 16'd2, 0, 4'h0, 4'h0);
        vecs[2]  = mk(0, 4'h2, 0, 4'd0, 16'd0, 0, 4'h0, 4'h0);
        vecs[3]  = mk(0, 4'h2, 0, 4'd0, 16'd0, 0, 4'h0, 4'h0);
        vecs[4]  = mk(0, 4'h2, 0, 4'd0, 16'd0, 0, 4'h2, 4'h2);
        vecs[5]  = mk(0, 4'h2, 0, 4'd0, 16'd0, 0, 4'h2, 4'h0);
        vecs[6]  = mk(0, 4'h2, 1, 4'd1, 16'd0, 1, 4'h0, 4'h0);
        vecs[7]  = mk(0, 4'h2, 0, 4'd0, 16'd0, 0, 4'h2, 4'h2);
        vecs[8]  = mk(0, 4'h2, 0, 4'd0, 16'd0, 0, 4'h2, 4'h2);
        vecs[9]  = mk(0, 4'h2, 1, 4'd9, 16'd5, 0, 4'h2, 4'h2);
        vecs[10] = mk(0, 4'h2, 0, 4'd0, 16'd0, 0, 4'h2, 4'h2);
        vecs[11] = mk(0, 4'h0, 0, 4'd0, 16'd0, 0, 4'h0, 4'h0);
        vecs[12] = mk(0, 4'h0, 1, 4'd1, 16'd1, 0, 4'h0, 4'h0);
        vecs[13] = mk(0, 4'h2, 0, 4'd0, 16'd0, 0, 4'h0, 4'h0);
        vecs[14] = mk(0, 4'h2, 0, 4'd0, 16'd0, 0, 4'h2, 4'h2);
        vecs[15] = mk(0, 4'h2, 0, 4'd0, 16'd0, 0, 4'h2, 4'h0);
        vecs[16] = mk(0, 4'h2, 0, 4'd0, 16'd0, 0, 4'h0, 4'h2);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].we, vecs[i].ch, vecs[i].lim, vecs[i].mode);
            step($sformatf("vec%0d", i), vecs[i].eout, vecs[i].etick);
        end

        // Default limit on channel 0, then disable mid-count and re-enable
        drive(1'b1, 4'h1, 1'b0, 4'd0, 16'd0, 1'b0);
        step("a_reset", 4'h0, 4'h0);
        drive(1'b0, 4'h1, 1'b0, 4'd0, 16'd0, 1'b0);
        run_ch0("a_run", 45);
        drive(1'b0, 4'h0, 1'b0, 4'd0, 16'd0, 1'b0);
        for (int k = 0; k < 3; k++) step($sformatf("a_off%0d", k), 4'h0, 4'h0);
        drive(1'b0, 4'h1, 1'b0, 4'd0, 16'd0, 1'b0);
        run_ch0("a_reen", 13);

        // Channel 1 at L=0 in pulse mode fires every cycle
        drive(1'b1, 4'h0, 1'b0, 4'd0, 16'd0, 1'b0);
        step("b_reset", 4'h0, 4'h0);
        drive(1'b0, 4'h0, 1'b1, 4'd1, 16'd0, 1'b1);
        step("b_write", 4'h0, 4'h0);
        drive(1'b0, 4'h2, 1'b0, 4'd0, 16'd0, 1'b0);
        for (int k = 0; k < 5; k++) step($sformatf("b_run%0d", k), 4'h2, 4'h2);

        // Channel 2: lower L from 20 to 5 while the count sits at 15
        drive(1'b1, 4'h0, 1'b0, 4'd0, 16'd0, 1'b0);
        step("c_reset", 4'h0, 4'h0);
        drive(1'b0, 4'h0, 1'b1, 4'd2, 16'd20, 1'b0);
        step("c_write20", 4'h0, 4'h0);
        drive(1'b0, 4'h4, 1'b0, 4'd0, 16'd0, 1'b0);
        for (int k = 0; k < 15; k++) step($sformatf("c_up%0d", k), 4'h0, 4'h0);
        drive(1'b0, 4'h4, 1'b1, 4'd2, 16'd5, 1'b0);
        step("c_write5", 4'h0, 4'h0);
        drive(1'b0, 4'h4, 1'b0, 4'd0, 16'd0, 1'b0);
        for (int j = 1; j <= 14; j++) begin
            logic t;
            logic o;
            t = ((j - 1) % 6) == 0;
            o = ((((j - 1) / 6) + 1) % 2) == 1;
            step($sformatf("c_j%0d", j), {1'b0, o, 2'b00}, {1'b0, t, 2'b00});
        end

        // Channel 3: write L=6 in the same cycle as a terminal event on L=3
        drive(1'b1, 4'h0, 1'b0, 4'd0, 16'd0, 1'b0);
        step("d_reset", 4'h0, 4'h0);
        drive(1'b0, 4'h0, 1'b1, 4'd3, 16'd3, 1'b0);
        step("d_write3", 4'h0, 4'h0);
        drive(1'b0, 4'h8, 1'b0, 4'd0, 16'd0, 1'b0);
        for (int k = 0; k < 3; k++) step($sformatf("d_k%0d", k), 4'h0, 4'h0);
        drive(1'b0, 4'h8, 1'b1, 4'd3, 16'd6, 1'b0);
        step("d_k3_term", 4'h8, 4'h8);
        drive(1'b0, 4'h8, 1'b0, 4'd0, 16'd0, 1'b0);
        for (int k = 4; k < 13; k++) begin
            step($sformatf("d_k%0d", k), (k < 10) ? 4'h8 : 4'h0, (k == 10) ? 4'h8 : 4'h0);
        end

        // Out-of-range write, then reset mid-count overriding enable and write
        drive(1'b1, 4'h0, 1'b0, 4'd0, 16'd0, 1'b0);
        step("e_reset", 4'h0, 4'h0);
        for (int k = 0; k < 14; k++) begin
            drive(1'b0, 4'hF, (k == 2), 4'd7, 16'd0, 1'b1);
            step($sformatf("e_k%0d", k), (k >= 9) ? 4'hF : 4'h0, (k == 9) ? 4'hF : 4'h0);
        end
        drive(1'b1, 4'hF, 1'b1, 4'd0, 16'd0, 1'b1);
        step("e_midreset", 4'h0, 4'h0);
        drive(1'b0, 4'hF, 1'b0, 4'd0, 16'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step($sformatf("e_post%0d", k), (k == 9) ? 4'hF : 4'h0, (k == 9) ? 4'hF : 4'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
